traffic_light_ctrl: RTL and testbench
=====================================

# traffic_light_ctrl

Two-road intersection controller (main road / side road) that sequences the per-phase seconds countdown and decodes lamp outputs. It consumes a one-cycle-per-second `tick` enable from the prescaler and a side-road vehicle request. It owns a loadable down-counter that holds the remaining seconds of the current phase. A flash override forces blinking fault/night mode.

## Interface
- pGREEN_MAIN, 30, minimum main-road green, seconds
- pGREEN_SIDE, 20, side-road green, seconds
- pYELLOW, 3, yellow duration for both roads, seconds
- pALL_RED, 1, all-red clearance between roads, seconds
- clk  in  1  system clock; one clock domain
- rst_n  in  1  reset, asynchronous, active-low
- tick  in  1  one-cycle pulse, once per second
- side_req  in  1  side-road vehicle detector, level, sampled every clk
- flash  in  1  flash-mode override, level
- main_lamp  out  3  {R,Y,G}
- side_lamp  out  3  {R,Y,G}
- phase  out  3  current state encoding (phase_e)
- count  out  CW  remaining seconds in phase minus one; CW = $clog2(max duration param + 1)
- phase_change  out  1  one-cycle pulse on the clock after any state change

## Operation
- States:
  - S_MAIN_G: main G, side R
  - S_MAIN_Y: main Y, side R
  - S_RED_MS: both R
  - S_SIDE_G: main R, side G
  - S_SIDE_Y: main R, side Y
  - S_RED_SM: both R
  - S_FLASH: main {0,blink,0}, side {blink,0,0}
- Phase entry loads count = duration-1.
- On each tick with count>0: count decrements.
- On tick with count==0: advance to the next state, except in S_MAIN_G.
- S_MAIN_G with count==0:
  - stays at count 0 (rests in green) until req_pending.
  - Exits on the first tick where count==0 and req_pending are both true.
- Cycle order: MAIN_G → MAIN_Y → RED_MS → SIDE_G → SIDE_Y → RED_SM → MAIN_G.
- req_pending:
  - Set on any clk with side_req=1.
  - Cleared on the edge entering S_SIDE_G; clear wins over a simultaneous set.
  - Retained through all other states, so a request during side green or yellow causes another side service.
- flash=1 on any edge, from any state, with or without tick:
  - Go to S_FLASH; blink=1.
  - Priority over all tick transitions.
  - In S_FLASH, blink toggles on each tick; count holds 0.
- flash=0 in S_FLASH: next edge goes to S_RED_SM with count=pALL_RED-1. Never jump directly to a green.
- Every duration must be ≥1 and ≤2^CW-1. Elaboration fails (`$error`) otherwise.

## Timing
- Reset values:
  - state=S_RED_SM, count=pALL_RED-1
  - main_lamp=3'b100, side_lamp=3'b100
  - req_pending=0, blink=1, phase_change=0
- A phase of duration D lasts exactly D ticks. Transition happens on the clock edge that samples the D-th tick.
- Lamps and phase are Moore-decoded from the state register: valid the same cycle the state register updates, with no extra latency.
- phase_change is registered: high for exactly one cycle, the cycle after the transition edge.
- tick held high for multiple cycles is counted once per cycle; no edge detection is performed.
- Reset asserted mid-phase: asynchronous return to reset values. After release, the first tick is counted normally.
- At most one green is ever lit. Any green is always preceded by ≥1 all-red phase.

## Structure
- Package traffic_pkg:
  - phase_e enum (the 7 states, 3-bit)
  - lamp localparams LAMP_R=3'b100, LAMP_Y=3'b010, LAMP_G=3'b001, LAMP_OFF=3'b000
- Sub-module phase_timer:
  - Loadable down-counter.
  - Inputs: load, load_val, en (=tick).
  - Outputs: count, last (count==0).
  - Load has priority over decrement; holds at 0.
- Controller logic: FSM, request latch, blink flop, lamp decode, phase_change flop.

## Test plan
Parameters: pGREEN_MAIN=5, pGREEN_SIDE=4, pYELLOW=2, pALL_RED=1, tick every 4 clk.
1. Reset, side_req=0, run 20 ticks → RED_SM for 1 tick, then MAIN_G with count 4→0, then rests in MAIN_G with count 0; phase_change pulses exactly once.
2. side_req pulse 1 clk at tick 2 of MAIN_G → MAIN_G 5, MAIN_Y 2, RED_MS 1, SIDE_G 4, SIDE_Y 2, RED_SM 1 ticks, then MAIN_G; req_pending=0 after SIDE_G entry.
3. side_req held high through SIDE_G → after returning to MAIN_G, a full 5-tick green, then a second side service.
4. side_req pulse exactly on the SIDE_G entry edge → cleared (clear wins); no second service.
5. flash=1 mid SIDE_G without tick → next edge S_FLASH; main_lamp alternates 010/000 and side_lamp 100/000 per tick. flash=0 → RED_SM (count 0), then MAIN_G after 1 tick.
6. rst_n low mid MAIN_Y, asynchronous to clk → immediately state=S_RED_SM, lamps 100/100, count=0, req_pending=0.

Source files
------------

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_pkg
// Brief    : Shared phase encoding, lamp codes and helpers for the
//            two-road intersection controller.
// Revision : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    typedef enum logic [2:0] {
        S_MAIN_G = 3'd0,
        S_MAIN_Y = 3'd1,
        S_RED_MS = 3'd2,
        S_SIDE_G = 3'd3,
        S_SIDE_Y = 3'd4,
        S_RED_SM = 3'd5,
        S_FLASH  = 3'd6
    } phase_e;

    // Lamp vectors are ordered {R,Y,G}
    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : phase_timer
// Brief    : Loadable seconds down-counter; load beats decrement, holds at 0.
// Revision : 1.0 - initial release
// ============================================================================
module phase_timer #(
    parameter int              CW      = 5,
    parameter logic [CW-1:0]   RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          last
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= RST_VAL;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count = r_count;
    assign last  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_ctrl
// Brief    : Main/side intersection sequencer with request latch, seconds
//            countdown and flash override.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int pGREEN_MAIN = 30,
    parameter int pGREEN_SIDE = 20,
    parameter int pYELLOW     = 3,
    parameter int pALL_RED    = 1,
    // Derived width; not meant to be overridden
    parameter int CW          = $clog2(max4(pGREEN_MAIN, pGREEN_SIDE, pYELLOW, pALL_RED) + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          side_req,
    input  logic          flash,
    output logic [2:0]    main_lamp,
    output logic [2:0]    side_lamp,
    output logic [2:0]    phase,
    output logic [CW-1:0] count,
    output logic          phase_change
);

    localparam int            C_DUR_MAX     = (2 ** CW) - 1;
    localparam logic [CW-1:0] c_main_g_load = CW'(pGREEN_MAIN - 1);
    localparam logic [CW-1:0] c_side_g_load = CW'(pGREEN_SIDE - 1);
    localparam logic [CW-1:0] c_yellow_load = CW'(pYELLOW - 1);
    localparam logic [CW-1:0] c_red_load    = CW'(pALL_RED - 1);

    if (pGREEN_MAIN < 1 || pGREEN_MAIN > C_DUR_MAX ||
        pGREEN_SIDE < 1 || pGREEN_SIDE > C_DUR_MAX ||
        pYELLOW     < 1 || pYELLOW     > C_DUR_MAX ||
        pALL_RED    < 1 || pALL_RED    > C_DUR_MAX) begin : g_bad_duration
        $error("traffic_light_ctrl: every phase duration must be in 1..2^CW-1");
    end

    phase_e        r_state;
    phase_e        w_state_next;
    logic          r_req_pending;
    logic          r_blink;
    logic          r_phase_change;
    logic          w_load;
    logic [CW-1:0] w_load_val;
    logic          w_last;
    logic          w_enter_side_g;
    logic          w_enter_flash;

    phase_timer #(
        .CW      (CW),
        .RST_VAL (c_red_load)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (w_load_val),
        .en       (tick),
        .count    (count),
        .last     (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RED_SM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Flash wins over every timed transition; leaving flash always clears through all-red
    always_comb begin
        w_state_next = r_state;
        if (flash) begin
            w_state_next = S_FLASH;
        end else begin
            case (r_state)
                S_MAIN_G: if (tick && w_last && r_req_pending) w_state_next = S_MAIN_Y;
                S_MAIN_Y: if (tick && w_last) w_state_next = S_RED_MS;
                S_RED_MS: if (tick && w_last) w_state_next = S_SIDE_G;
                S_SIDE_G: if (tick && w_last) w_state_next = S_SIDE_Y;
                S_SIDE_Y: if (tick && w_last) w_state_next = S_RED_SM;
                S_RED_SM: if (tick && w_last) w_state_next = S_MAIN_G;
                S_FLASH:  w_state_next = S_RED_SM;
                default:  w_state_next = S_RED_SM;
            endcase
        end
    end

    assign w_load         = (w_state_next != r_state);
    assign w_enter_side_g = w_load && (w_state_next == S_SIDE_G);
    assign w_enter_flash  = w_load && (w_state_next == S_FLASH);

    always_comb begin
        w_load_val = '0;
        case (w_state_next)
            S_MAIN_G:           w_load_val = c_main_g_load;
            S_MAIN_Y, S_SIDE_Y: w_load_val = c_yellow_load;
            S_RED_MS, S_RED_SM: w_load_val = c_red_load;
            S_SIDE_G:           w_load_val = c_side_g_load;
            default:            w_load_val = '0;
        endcase
    end

    // Clear on side-green entry beats a same-edge request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_pending <= 1'b0;
        end else if (w_enter_side_g) begin
            r_req_pending <= 1'b0;
        end else if (side_req) begin
            r_req_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink <= 1'b1;
        end else if (w_enter_flash) begin
            r_blink <= 1'b1;
        end else if ((r_state == S_FLASH) && tick) begin
            r_blink <= ~r_blink;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase_change <= 1'b0;
        end else begin
            r_phase_change <= w_load;
        end
    end

    always_comb begin
        main_lamp = LAMP_R;
        side_lamp = LAMP_R;
        case (r_state)
            S_MAIN_G: main_lamp = LAMP_G;
            S_MAIN_Y: main_lamp = LAMP_Y;
            S_SIDE_G: side_lamp = LAMP_G;
            S_SIDE_Y: side_lamp = LAMP_Y;
            S_FLASH: begin
                main_lamp = r_blink ? LAMP_Y : LAMP_OFF;
                side_lamp = r_blink ? LAMP_R : LAMP_OFF;
            end
            default: begin
                main_lamp = LAMP_R;
                side_lamp = LAMP_R;
            end
        endcase
    end

    assign phase        = r_state;
    assign phase_change = r_phase_change;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_light_ctrl
// Brief    : Scoreboard bench for traffic_light_ctrl (5/4/2/1 s, tick every 4 clk).
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_light_ctrl;
    import traffic_pkg::*;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       tick     = 1'b0;
    logic       side_req = 1'b0;
    logic       flash    = 1'b0;
    logic [2:0] main_lamp;
    logic [2:0] side_lamp;
    logic [2:0] phase;
    logic [2:0] count;
    logic       phase_change;

    int n_total  = 0;
    int n_pass   = 0;
    int pc_seen  = 0;
    int tick_acc = 0;

    // Expected phase entry: new phase, its lamps and loaded count, ticks spent in the phase left (-1 = any)
    typedef struct {
        logic [2:0] ph;
        logic [2:0] ml;
        logic [2:0] sl;
        int         cnt;
        int         ticks;
    } exp_t;
    exp_t sb[$];

    traffic_light_ctrl #(
        .pGREEN_MAIN (5),
        .pGREEN_SIDE (4),
        .pYELLOW     (2),
        .pALL_RED    (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .side_req     (side_req),
        .flash        (flash),
        .main_lamp    (main_lamp),
        .side_lamp    (side_lamp),
        .phase        (phase),
        .count        (count),
        .phase_change (phase_change)
    );

    always #5 clk = ~clk;

    initial begin
        int c;
        c = 0;
        forever begin
            @(posedge clk);
            #1;
            tick = ((c % 4) == 3);
            c++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic expect_entry(input logic [2:0] ph, input int ticks);
        exp_t e;
        e.ph    = ph;
        e.ticks = ticks;
        case (ph)
            S_MAIN_G: begin e.ml = 3'b001; e.sl = 3'b100; e.cnt = 4; end
            S_MAIN_Y: begin e.ml = 3'b010; e.sl = 3'b100; e.cnt = 1; end
            S_RED_MS: begin e.ml = 3'b100; e.sl = 3'b100; e.cnt = 0; end
            S_SIDE_G: begin e.ml = 3'b100; e.sl = 3'b001; e.cnt = 3; end
            S_SIDE_Y: begin e.ml = 3'b100; e.sl = 3'b010; e.cnt = 1; end
            S_RED_SM: begin e.ml = 3'b100; e.sl = 3'b100; e.cnt = 0; end
            default:  begin e.ml = 3'b010; e.sl = 3'b100; e.cnt = 0; end
        endcase
        sb.push_back(e);
    endtask

    // Normal side service from a resting main green
    task automatic expect_service(input int main_ticks);
        expect_entry(S_MAIN_Y, main_ticks);
        expect_entry(S_RED_MS, 2);
        expect_entry(S_SIDE_G, 1);
        expect_entry(S_SIDE_Y, 4);
        expect_entry(S_RED_SM, 2);
        expect_entry(S_MAIN_G, 1);
    endtask

    task automatic wait_phase(input logic [2:0] target);
        int g;
        g = 0;
        while (phase !== target && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (phase !== target) begin
            n_total++;
            $display("FAIL wait_phase: phase=%0d expected %0d (timeout)", phase, target);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int g;
            g = 0;
            @(negedge clk);
            while (!tick && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (!tick) begin
                n_total++;
                $display("FAIL wait_ticks: tick=%0b expected 1 (timeout)", tick);
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_req();
        side_req = 1'b1;
        @(negedge clk);
        side_req = 1'b0;
    endtask

    // Monitor: every phase_change pulse presents a new phase to compare
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tick_acc = 0;
            end else begin
                if (phase_change) begin
                    pc_seen++;
                    n_total++;
                    if (sb.size() == 0) begin
                        $display("FAIL phase_entry: unexpected change to phase=%0d, expected no change", phase);
                    end else begin
                        e = sb.pop_front();
                        if (phase === e.ph && main_lamp === e.ml && side_lamp === e.sl &&
                            int'(count) == e.cnt && (e.ticks < 0 || tick_acc == e.ticks))
                            n_pass++;
                        else
                            $display("FAIL phase_entry: got phase=%0d lamps=%b/%b count=%0d ticks=%0d, expected phase=%0d lamps=%b/%b count=%0d ticks=%0d",
                                     phase, main_lamp, side_lamp, count, tick_acc,
                                     e.ph, e.ml, e.sl, e.cnt, e.ticks);
                    end
                    tick_acc = 0;
                end
                if (tick) tick_acc++;
            end
        end
    end

    initial begin
        int g;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_phase", phase, S_RED_SM);
        check("rst_main_lamp", main_lamp, 3'b100);
        check("rst_side_lamp", side_lamp, 3'b100);
        check("rst_count", count, 0);
        check("rst_phase_change", phase_change, 0);

        // 1: no requests, green counts down then rests
        expect_entry(S_MAIN_G, 1);
        while (tick) @(negedge clk);
        rst_n = 1'b1;
        wait_phase(S_MAIN_G);
        for (int k = 3; k >= 0; k--) begin
            wait_ticks(1);
            check("main_g_countdown", count, k);
        end
        wait_ticks(15);
        check("rest_phase", phase, S_MAIN_G);
        check("rest_count", count, 0);
        check("single_phase_change", pc_seen, 1);

        // 2: request from rest, then a request at tick 2 of a fresh green
        expect_service(-1);
        pulse_req();
        wait_phase(S_SIDE_G);
        wait_phase(S_MAIN_G);
        expect_service(5);
        wait_ticks(2);
        pulse_req();
        wait_phase(S_SIDE_G);
        wait_phase(S_MAIN_G);
        wait_ticks(8);
        check("no_extra_service", phase, S_MAIN_G);

        // 3: request held through side green forces a second service
        expect_service(-1);
        expect_service(5);
        side_req = 1'b1;
        wait_phase(S_SIDE_Y);
        side_req = 1'b0;
        wait_phase(S_MAIN_G);
        wait_phase(S_SIDE_G);
        wait_phase(S_MAIN_G);
        wait_ticks(8);
        check("held_req_two_services", phase, S_MAIN_G);

        // 4: request on the side-green entry edge is swallowed by the clear
        expect_service(-1);
        pulse_req();
        g = 0;
        while (!(phase == S_RED_MS && tick) && g < 400) begin
            @(negedge clk);
            g++;
        end
        check("reach_red_ms_tick", phase, S_RED_MS);
        pulse_req();
        wait_phase(S_MAIN_G);
        wait_ticks(8);
        check("clear_wins", phase, S_MAIN_G);

        // 5: flash during side green, blink per tick, exit through all-red
        expect_entry(S_MAIN_Y, -1);
        expect_entry(S_RED_MS, 2);
        expect_entry(S_SIDE_G, 1);
        expect_entry(S_FLASH, 1);
        expect_entry(S_RED_SM, 4);
        expect_entry(S_MAIN_G, 1);
        pulse_req();
        wait_phase(S_SIDE_G);
        wait_ticks(1);
        flash = 1'b1;
        wait_phase(S_FLASH);
        for (int i = 1; i <= 4; i++) begin
            wait_ticks(1);
            check("flash_main_lamp", main_lamp, (i % 2) ? 3'b000 : 3'b010);
            check("flash_side_lamp", side_lamp, (i % 2) ? 3'b000 : 3'b100);
            check("flash_count", count, 0);
        end
        flash = 1'b0;
        wait_phase(S_RED_SM);
        wait_phase(S_MAIN_G);

        // 6: asynchronous reset in main yellow drops pending request too
        expect_entry(S_MAIN_Y, -1);
        pulse_req();
        wait_phase(S_MAIN_Y);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_phase", phase, S_RED_SM);
        check("async_rst_main_lamp", main_lamp, 3'b100);
        check("async_rst_side_lamp", side_lamp, 3'b100);
        check("async_rst_count", count, 0);
        repeat (3) @(negedge clk);
        expect_entry(S_MAIN_G, 1);
        while (tick) @(negedge clk);
        rst_n = 1'b1;
        wait_phase(S_MAIN_G);
        wait_ticks(8);
        check("rst_clears_pending", phase, S_MAIN_G);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
